// File: rtl/key_pkg.sv
// Shared definitions for the key filter array: one-hot channel FSM states and
// helpers for sizing the debounce and hold counters.
package key_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      FILTER0 = 4'b0010,
      DOWN    = 4'b0100,
      FILTER1 = 4'b1000
   } key_fsm_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $unsigned($clog2(n));
   endfunction

endpackage

// File: rtl/key_filter_array_if.sv
// Key pins in, per-key debounced events and levels out.
interface key_filter_array_if #(
   parameter int unsigned N_KEYS = 4
);

   logic [N_KEYS-1:0] key_in;
   logic [N_KEYS-1:0] key_flag;
   logic [N_KEYS-1:0] key_state;
   logic [N_KEYS-1:0] key_long;
   logic [N_KEYS-1:0] key_rep;

   modport master (
      output key_in,
      input  key_flag,
      input  key_state,
      input  key_long,
      input  key_rep
   );

   modport slave (
      input  key_in,
      output key_flag,
      output key_state,
      output key_long,
      output key_rep
   );

endinterface

// File: rtl/key_filter_ch.sv
// One debounced key channel: 2-flop synchroniser, press/release filter FSM,
// long-press detection and optional auto-repeat.
module key_filter_ch
   import key_pkg::*;
#(
   parameter int unsigned DEB_CYC   = 1_000_000,
   parameter int unsigned LONG_CYC  = 50_000_000,
   parameter int unsigned REP_CYC   = 10_000_000,
   parameter bit          REPEAT_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_flag,
   output logic key_state,
   output logic key_long,
   output logic key_rep
);

   localparam int unsigned CW = cnt_width(DEB_CYC);
   localparam int unsigned HW = cnt_width(max_u(LONG_CYC, REP_CYC));

   localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REP_CYC - 1);

   logic [1:0]    sync_q;
   logic          s;
   key_fsm_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          long_done_q, long_done_d;
   logic          flag_q, flag_d;
   logic          level_q, level_d;
   logic          long_q, long_d;
   logic          rep_q, rep_d;

   assign s = sync_q[1];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      long_done_d = long_done_q;
      flag_d      = 1'b0;
      level_d     = level_q;
      long_d      = 1'b0;
      rep_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!s) begin
               state_d = FILTER0;
               cnt_d   = '0;
            end
         end

         FILTER0: begin
            if (s) begin
               state_d = IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d     = DOWN;
               flag_d      = 1'b1;
               level_d     = 1'b0;
               hold_d      = '0;
               long_done_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DOWN: begin
            if (s) begin
               state_d = FILTER1;
               cnt_d   = '0;
            end else if (!long_done_q) begin
               if (hold_q == LONG_LAST) begin
                  long_d      = 1'b1;
                  long_done_d = 1'b1;
                  hold_d      = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end else if (REPEAT_EN) begin
               if (hold_q == REP_LAST) begin
                  rep_d  = 1'b1;
                  hold_d = '0;
               end else begin
                  hold_d = hold_q + HW'(1);
               end
            end
            // Without repeat, hold_cnt parks once key_long has fired.
         end

         FILTER1: begin
            if (!s) begin
               state_d = DOWN;
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
               flag_d  = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d     = IDLE;
            cnt_d       = '0;
            hold_d      = '0;
            long_done_d = 1'b0;
            level_d     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         state_q     <= IDLE;
         cnt_q       <= '0;
         hold_q      <= '0;
         long_done_q <= 1'b0;
         flag_q      <= 1'b0;
         level_q     <= 1'b1;
         long_q      <= 1'b0;
         rep_q       <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], key_in};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         long_done_q <= long_done_d;
         flag_q      <= flag_d;
         level_q     <= level_d;
         long_q      <= long_d;
         rep_q       <= rep_d;
      end
   end

   assign key_flag  = flag_q;
   assign key_state = level_q;
   assign key_long  = long_q;
   assign key_rep   = rep_q;

endmodule

// File: rtl/key_filter_array.sv
// Array of N_KEYS independent debounced key channels behind one interface.
module key_filter_array
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS    = 4,
   parameter int unsigned DEB_CYC   = 1_000_000,
   parameter int unsigned LONG_CYC  = 50_000_000,
   parameter int unsigned REP_CYC   = 10_000_000,
   parameter bit          REPEAT_EN = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   key_filter_array_if.slave bus
);

   logic [N_KEYS-1:0] flag_v;
   logic [N_KEYS-1:0] state_v;
   logic [N_KEYS-1:0] long_v;
   logic [N_KEYS-1:0] rep_v;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_filter_ch #(
         .DEB_CYC   (DEB_CYC),
         .LONG_CYC  (LONG_CYC),
         .REP_CYC   (REP_CYC),
         .REPEAT_EN (REPEAT_EN)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .key_in    (bus.key_in[i]),
         .key_flag  (flag_v[i]),
         .key_state (state_v[i]),
         .key_long  (long_v[i]),
         .key_rep   (rep_v[i])
      );
   end

   assign bus.key_flag  = flag_v;
   assign bus.key_state = state_v;
   assign bus.key_long  = long_v;
   assign bus.key_rep   = rep_v;

endmodule

// File: tb/tb_key_filter_array.sv
// Directed bench for key_filter_array with short timing parameters; a second
// instance with repeat disabled shares the same key stimulus.
module tb_key_filter_array;

   localparam int unsigned NK = 4;

   logic clk;
   logic rst_n;

   key_filter_array_if #(.N_KEYS(NK)) kif0 ();
   key_filter_array_if #(.N_KEYS(NK)) kif1 ();

   assign kif1.key_in = kif0.key_in;

   key_filter_array #(
      .N_KEYS    (NK),
      .DEB_CYC   (4),
      .LONG_CYC  (20),
      .REP_CYC   (8),
      .REPEAT_EN (1'b1)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kif0)
   );

   key_filter_array #(
      .N_KEYS    (NK),
      .DEB_CYC   (4),
      .LONG_CYC  (20),
      .REP_CYC   (8),
      .REPEAT_EN (1'b0)
   ) u_dut_norep (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kif1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int long2_cnt;
   logic [NK-1:0] flag_acc, long_acc, rep_acc, rep2_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      flag_acc  = '0;
      long_acc  = '0;
      rep_acc   = '0;
      rep2_acc  = '0;
      long2_cnt = 0;
   endtask

   // One clock edge; outputs are sampled 1 ns later and folded into the accumulators.
   task automatic tick();
      @(posedge clk);
      #1;
      flag_acc  |= kif0.key_flag;
      long_acc  |= kif0.key_long;
      rep_acc   |= kif0.key_rep;
      rep2_acc  |= kif1.key_rep;
      long2_cnt += $countones(kif1.key_long);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      clr();
      kif0.key_in = 4'hF;
      rst_n = 1'b0;
      ticks(3);
      chk("rst_flag", kif0.key_flag, 4'h0);
      chk("rst_state", kif0.key_state, 4'hF);
      chk("rst_long", kif0.key_long, 4'h0);
      chk("rst_rep", kif0.key_rep, 4'h0);
      rst_n = 1'b1;
      ticks(3);

      // Clean press on key 0: edge 0 is the next sample, flag at edge 6.
      clr();
      kif0.key_in[0] = 1'b0;
      ticks(6);
      chk("clean_no_early_flag", flag_acc, 4'h0);
      tick();
      chk("clean_press_flag", kif0.key_flag, 4'b0001);
      chk("clean_press_state", kif0.key_state, 4'b1110);
      clr();
      ticks(3);
      chk("clean_flag_one_cycle", flag_acc, 4'h0);
      kif0.key_in[0] = 1'b1;
      ticks(6);
      chk("clean_no_early_rel", flag_acc | long_acc, 4'h0);
      tick();
      chk("clean_rel_flag", kif0.key_flag, 4'b0001);
      chk("clean_rel_state", kif0.key_state, 4'hF);
      tick();
      chk("clean_rel_clear", kif0.key_flag, 4'h0);

      // Bounce on key 1: low 2, high 1, then low; flag 6 edges after last low start.
      clr();
      kif0.key_in[1] = 1'b0;
      ticks(2);
      kif0.key_in[1] = 1'b1;
      tick();
      kif0.key_in[1] = 1'b0;
      ticks(6);
      chk("bounce_no_early_flag", flag_acc, 4'h0);
      tick();
      chk("bounce_press_flag", kif0.key_flag, 4'b0010);
      chk("bounce_press_state", kif0.key_state, 4'b1101);
      ticks(4);
      // Release with a one-sample low glitch while in FILTER1.
      clr();
      kif0.key_in[1] = 1'b1;
      ticks(2);
      kif0.key_in[1] = 1'b0;
      tick();
      kif0.key_in[1] = 1'b1;
      ticks(6);
      chk("glitch_no_flag", flag_acc, 4'h0);
      chk("glitch_still_down", kif0.key_state, 4'b1101);
      tick();
      chk("glitch_rel_flag", kif0.key_flag, 4'b0010);
      chk("glitch_rel_state", kif0.key_state, 4'hF);
      ticks(3);

      // Long press on key 2: DOWN at edge 6, long at 26, repeats at 34/42/50/58.
      clr();
      kif0.key_in[2] = 1'b0;
      ticks(26);
      chk("long_not_early", long_acc | rep_acc, 4'h0);
      tick();
      chk("long_pulse", kif0.key_long, 4'b0100);
      chk("long_no_rep", kif0.key_rep, 4'h0);
      chk("norep_long_pulse", kif1.key_long, 4'b0100);
      long_acc = '0;
      ticks(7);
      chk("rep_not_early", rep_acc | long_acc, 4'h0);
      tick();
      chk("rep_pulse_0", kif0.key_rep, 4'b0100);
      for (int k = 1; k < 4; k++) begin
         rep_acc = '0;
         ticks(7);
         chk($sformatf("rep_gap_%0d", k), rep_acc, 4'h0);
         tick();
         chk($sformatf("rep_pulse_%0d", k), kif0.key_rep, 4'b0100);
      end
      tick();
      kif0.key_in[2] = 1'b1;
      flag_acc = '0;
      rep_acc  = '0;
      long_acc = '0;
      ticks(6);
      chk("long_rel_quiet", flag_acc | rep_acc | long_acc, 4'h0);
      tick();
      chk("long_rel_flag", kif0.key_flag, 4'b0100);
      chk("long_rel_state", kif0.key_state, 4'hF);
      ticks(10);
      chk("long_no_rep_after", rep_acc, 4'h0);
      chk("norep_long_once", long2_cnt, 1);
      chk("norep_rep_zero", rep2_acc, 4'h0);

      // Simultaneous press on all keys.
      clr();
      kif0.key_in = 4'h0;
      ticks(6);
      chk("all_no_early", flag_acc, 4'h0);
      tick();
      chk("all_flag", kif0.key_flag, 4'hF);
      chk("all_state", kif0.key_state, 4'h0);
      kif0.key_in = 4'hF;
      tick();
      chk("all_flag_clear", kif0.key_flag, 4'h0);
      ticks(12);
      chk("all_released", kif0.key_state, 4'hF);

      // Reset while key 0 is down and key 3 is mid-FILTER0.
      kif0.key_in[0] = 1'b0;
      ticks(3);
      kif0.key_in[3] = 1'b0;
      ticks(4);
      chk("pre_rst_state", kif0.key_state, 4'b1110);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_state", kif0.key_state, 4'hF);
      chk("rst_mid_flag", kif0.key_flag, 4'h0);
      kif0.key_in = 4'hF;
      ticks(2);
      rst_n = 1'b1;
      clr();
      ticks(3);
      chk("post_rst1_quiet", flag_acc | long_acc | rep_acc, 4'h0);
      chk("post_rst1_state", kif0.key_state, 4'hF);

      // Reset in the same cycle key_long is high.
      clr();
      kif0.key_in[3] = 1'b0;
      ticks(26);
      tick();
      chk("k3_long_pulse", kif0.key_long, 4'b1000);
      rst_n = 1'b0;
      #1;
      chk("rst_long_clear", kif0.key_long, 4'h0);
      chk("rst_long_state", kif0.key_state, 4'hF);
      kif0.key_in = 4'hF;
      ticks(2);
      rst_n = 1'b1;
      clr();
      ticks(3);
      chk("post_rst2_quiet", flag_acc | long_acc | rep_acc, 4'h0);
      chk("post_rst2_state", kif0.key_state, 4'hF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
